// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer:
// sequencer state encoding and default widths.
package pipe_pkg;

   localparam int DEFAULT_REG_W = 5;
   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != CNT_MAX)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: decodes memory freeze,
// EX redirects and load-use hazards into pipeline register enables/flushes.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_W       = DEFAULT_REG_W,
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic             ex_branch_taken_i,
   input  logic             ex_jump_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   input  logic             cnt_clr_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_write_o,
   output logic             idex_flush_o,
   output logic             exmem_write_o,
   output logic             memwb_bubble_o,
   output logic             state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             mem_err_o
);

   localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam logic [0:0]        S_RUN      = RUN;
   localparam logic [0:0]        S_MEM_WAIT = MEM_WAIT;

   logic              w_freeze;
   logic              w_redirect;
   logic              w_loadUse;
   logic              w_stallInc;
   logic              w_flushInc;
   logic [0:0]        r_state;
   logic [0:0]        w_stateNext;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_waitNext;
   logic              r_memErr;

   assign w_freeze   = mem_req_i & ~mem_ack_i;
   assign w_redirect = ex_branch_taken_i | ex_jump_i;
   assign w_loadUse  = idex_memread_i & (idex_rt_i != '0) &
                       ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));

   // Only the highest-priority condition shapes the controls; reset forces everything idle.
   always_comb begin
      pc_write_o     = 1'b1;
      ifid_write_o   = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_write_o   = 1'b1;
      idex_flush_o   = 1'b0;
      exmem_write_o  = 1'b1;
      memwb_bubble_o = 1'b0;
      if (rst) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_write_o  = 1'b0;
         exmem_write_o = 1'b0;
      end else if (w_freeze) begin
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         idex_write_o   = 1'b0;
         exmem_write_o  = 1'b0;
         memwb_bubble_o = 1'b1;
      end else if (w_redirect) begin
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else if (w_loadUse) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_flush_o = 1'b1;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_RUN:      if (w_freeze) w_stateNext = S_MEM_WAIT;
         S_MEM_WAIT: if (mem_ack_i || !mem_req_i) w_stateNext = S_RUN;
         default:    w_stateNext = S_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Wait counter sticks at the timeout so a long freeze cannot wrap it back below.
   always_comb begin
      w_waitNext = '0;
      if (w_freeze) begin
         w_waitNext = (r_wait == WAIT_MAX) ? r_wait : r_wait + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait <= '0;
      end else begin
         r_wait <= w_waitNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_memErr <= 1'b0;
      end else if (cnt_clr_i) begin
         r_memErr <= 1'b0;
      end else if (w_waitNext == WAIT_MAX) begin
         r_memErr <= 1'b1;
      end
   end

   assign w_stallInc = w_freeze | (w_loadUse & ~w_redirect);
   assign w_flushInc = w_redirect & ~w_freeze;

   sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_stallInc),
      .i_clr   (cnt_clr_i),
      .o_count (stall_cnt_o)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_flushInc),
      .i_clr   (cnt_clr_i),
      .o_count (flush_cnt_o)
   );

   assign state_o   = r_state;
   assign mem_err_o = r_memErr;

endmodule
